grant_mux_stage: RTL and testbench
==================================

Name: grant_mux_stage

Overview:
- Downstream consumer of wrr_arbiter's one-hot grant.
- Steers the granted requester's valid/data onto one registered output stream with valid/ready handshake, a 2-entry skid buffer and source-index tagging.
- Returns per-requester ready so upstream queues pop only on an actual transfer.
- Sits between wrr_arbiter (grant) and the shared downstream channel.

Parameters:
- WIDTH, 4, number of requesters; must match the arbiter's WIDTH.
- DWIDTH, 32, payload width per requester.
- SWIDTH, $clog2(WIDTH), width of the source index; derived, not overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- grant  input  WIDTH  one-hot grant from wrr_arbiter; all-zero means idle.
- in_valid  input  WIDTH  per-requester valid.
- in_data  input  WIDTH*DWIDTH  per-requester payload; requester i at bits [i*DWIDTH +: DWIDTH].
- in_ready  output  WIDTH  per-requester accept strobe.
- out_valid  output  1  output payload valid.
- out_data  output  DWIDTH  output payload.
- out_src  output  SWIDTH  index of the requester that produced out_data.
- out_ready  input  1  downstream accept.
- err_grant  output  1  sticky flag: grant had more than one bit set.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, out_src=0, err_grant=0, skid entry empty. in_ready is therefore grant & ~0.
- Combinational accept: in_ready[i] = grant[i] & ~skid_valid & ~grant_multi. Here grant_multi = popcount(grant)>1.
- A transfer from requester i occurs when in_ready[i] & in_valid[i]. At most one transfer per cycle.
- Latency: an accepted beat appears on out_valid/out_data/out_src on the next cycle, when the main register is empty or draining.
- Main register loads when a transfer occurs and (~out_valid | out_ready).
- If a transfer occurs while out_valid & ~out_ready, the beat goes to the skid entry and skid_valid=1.
- When the skid entry is full: in_ready=0 for all requesters. On the next out_ready the skid entry moves into the main register; skid_valid clears on that same edge.
- Simultaneous pop and push with main register full and skid empty: the main register takes the new beat. Throughput is 1 beat/cycle.
- out_valid stays high, with out_data and out_src stable, until out_ready. No combinational path from out_ready to out_valid.
- in_ready depends only on registered skid state and grant. There is no path from in_valid to in_ready.
- grant=0: no transfer. Output still drains.
- grant not one-hot: no transfer that cycle, and err_grant=1. err_grant clears only on reset.
- Grant change mid-stall is legal. Already-captured beats are unaffected.
- Reset mid-operation: buffered beats are discarded with no flush. out_valid drops asynchronously.
- out_src is the binary encoding of the one-hot grant bit captured with the beat.

Optional Feature:
- Macro GRANT_MUX_STATS_EN.
- Defined: adds ports stat_clr (input 1) and stat_cnt (output WIDTH*16).
  - Each per-requester 16-bit counter increments on each transfer from that requester.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Synchronous stat_clr zeroes all counters. A transfer in the same cycle as stat_clr is not counted.
  - Reset value is 0.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package grant_mux_pkg holds:
  - STAT_CWIDTH=16.
  - A function onehot2bin(WIDTH-bit) returning an SWIDTH-bit index.
  - A function popcount_gt1 for the grant check.
- One natural sub-module: skid_buffer. It is a 2-entry, parameterized-width valid/ready register slice holding {src, data}. grant_mux_stage instantiates it after the grant mux.

Test Plan:
- Reset: hold rst=0 for 3 cycles with grant=4'b0001 and in_valid=4'b1111 → out_valid=0, err_grant=0, in_ready=4'b0001. Also check no beat is captured.
- Streaming: out_ready=1, grant steps 0001,0010,0100,1000, in_data[i]=32'hA0+i → out_data 0xA0..0xA3, out_src 0..3, each one cycle after the transfer, 4 beats in 4 cycles.
- Backpressure: out_ready=0, grant=0010, in_valid=0010 → two beats accepted, then in_ready=0. Release out_ready → both beats emerge in order, out_src=1, and in_ready reasserts the cycle after the skid drains.
- Illegal grant: grant=4'b0110, in_valid=4'b1111 → in_ready=0, no out_valid, err_grant=1 persisting after grant=0001. Only rst=0 clears it.
- Idle and async reset: grant=0 → no transfer. Assert rst=0 mid-stall while out_valid=1 → out_valid drops before the next clock edge.
- With GRANT_MUX_STATS_EN:
  - 3 transfers from requester 2 → stat_cnt[2]=3.
  - stat_clr in the same cycle as a transfer → 0.
  - Preload via 65540 transfers → saturates at 0xFFFF.

Source files
------------

// File: rtl/grant_mux_pkg.sv
// Shared types and helpers for grant_mux_stage: stat counter width and grant decode functions.
// Helpers take a MAX_W-wide vector so they serve any WIDTH up to MAX_W; callers zero-extend.
package grant_mux_pkg;

    localparam int STAT_CWIDTH = 16;
    localparam int MAX_W       = 64;
    localparam int IDX_W       = 6;

    function automatic logic [IDX_W-1:0] onehot2bin(input logic [MAX_W-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++)
            if (oh[i]) idx = idx | IDX_W'(i);
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic popcount_gt1(input logic [MAX_W-1:0] v);
        return (v & (v - MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/grant_mux_stage_skid_buffer.sv
// skid_buffer: 2-entry valid/ready register slice. s_ready looks only at the registered
// skid entry, so there is no combinational path from m_ready or s_valid back to s_ready.
module skid_buffer #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         main_v, skid_v;
    logic [W-1:0] main_d, skid_d;
    logic         push, drain;

    assign s_ready = ~skid_v;
    assign push    = s_valid & s_ready;
    assign drain   = ~main_v | m_ready;
    assign m_valid = main_v;
    assign m_data  = main_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else if (drain) begin
            // skid entry always has priority; while it is full no push can occur
            if (skid_v) begin
                main_d <= skid_d;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (push) begin
                main_d <= s_data;
                main_v <= 1'b1;
            end else begin
                main_v <= 1'b0;
            end
        end else if (push) begin
            skid_d <= s_data;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: rtl/grant_mux_stage.sv
// grant_mux_stage: steers the one-hot granted requester onto a registered valid/ready stream
// tagged with its source index. Optional per-requester transfer counters: GRANT_MUX_STATS_EN.
module grant_mux_stage
    import grant_mux_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DWIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           grant,
    input  logic [WIDTH-1:0]           in_valid,
    input  logic [WIDTH*DWIDTH-1:0]    in_data,
    output logic [WIDTH-1:0]           in_ready,
    output logic                       out_valid,
    output logic [DWIDTH-1:0]          out_data,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] out_src,
    input  logic                       out_ready,
`ifdef GRANT_MUX_STATS_EN
    input  logic                       stat_clr,
    output logic [WIDTH*STAT_CWIDTH-1:0] stat_cnt,
`endif
    output logic                       err_grant
);

    localparam int SWIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                    grant_multi;
    logic                    skid_ready;
    logic                    xfer;
    logic [DWIDTH-1:0]       sel_data;
    logic [SWIDTH-1:0]       sel_src;
    logic [SWIDTH+DWIDTH-1:0] m_data;

    assign grant_multi = popcount_gt1(MAX_W'(grant));
    assign in_ready    = grant & {WIDTH{skid_ready & ~grant_multi}};
    assign xfer        = |(in_ready & in_valid);
    assign sel_src     = SWIDTH'(onehot2bin(MAX_W'(grant)));

    // grant is one-hot whenever a transfer happens, so OR-ing the selected lanes is a mux
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < WIDTH; i++)
            if (grant[i]) sel_data = sel_data | in_data[i*DWIDTH +: DWIDTH];
    end

    skid_buffer #(.W(SWIDTH + DWIDTH)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (xfer),
        .s_ready (skid_ready),
        .s_data  ({sel_src, sel_data}),
        .m_valid (out_valid),
        .m_ready (out_ready),
        .m_data  (m_data)
    );

    assign out_src  = m_data[SWIDTH+DWIDTH-1:DWIDTH];
    assign out_data = m_data[DWIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             err_grant <= 1'b0;
        else if (grant_multi) err_grant <= 1'b1;
    end

`ifdef GRANT_MUX_STATS_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_stat
        logic [STAT_CWIDTH-1:0] cnt;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                                    cnt <= '0;
            else if (stat_clr)                           cnt <= '0;
            else if (in_ready[i] && in_valid[i] && cnt != '1) cnt <= cnt + STAT_CWIDTH'(1);
        end
        assign stat_cnt[i*STAT_CWIDTH +: STAT_CWIDTH] = cnt;
    end
`endif

endmodule

// File: tb/tb_grant_mux_stage.sv
// Scoreboard bench for grant_mux_stage: stimulus pushes expected beats, a monitor pops them
// on each output handshake. The model tracks buffered beats as a plain count.
module tb_grant_mux_stage;

    localparam int W  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [W-1:0]      grant = '0;
    logic [W-1:0]      in_valid = '0;
    logic [W*DW-1:0]   in_data = '0;
    logic [W-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;
    logic              out_ready = 1'b0;
    logic              err_grant;
`ifdef GRANT_MUX_STATS_EN
    logic              stat_clr = 1'b0;
    logic [W*16-1:0]   stat_cnt;
    int                cnt_m [W];
`endif

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } beat_t;

    beat_t sb [$];
    int    pushed = 0;
    int    popped = 0;
    int    errors = 0;
    int    checks = 0;
    bit    err_m  = 1'b0;

    always #5 clk = ~clk;

    grant_mux_stage #(.WIDTH(W), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .grant     (grant),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
`ifdef GRANT_MUX_STATS_EN
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt),
`endif
        .err_grant (err_grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ones(input logic [W-1:0] g);
        int n = 0;
        for (int i = 0; i < W; i++) n += g[i];
        return n;
    endfunction

    function automatic logic [W*DW-1:0] rnd_data();
        logic [W*DW-1:0] d;
        for (int i = 0; i < W; i++) d[i*DW +: DW] = $urandom;
        return d;
    endfunction

    function automatic logic [W*DW-1:0] a_data();
        logic [W*DW-1:0] d;
        for (int i = 0; i < W; i++) d[i*DW +: DW] = 32'hA0 + DW'(i);
        return d;
    endfunction

    // One cycle: drive after the edge, check at +4, record what the next edge must do.
    task automatic step(input logic r, input logic [W-1:0] g, input logic [W-1:0] v,
                        input logic [W*DW-1:0] d, input logic ordy, input logic clr);
        int occ;
        int idx;
        logic [W-1:0] exp_rdy;
        @(posedge clk);
        #1;
        rst = r; grant = g; in_valid = v; in_data = d; out_ready = ordy;
`ifdef GRANT_MUX_STATS_EN
        stat_clr = clr;
`endif
        #3;
        if (!r) begin
            sb.delete();
            pushed = popped;
            err_m  = 1'b0;
`ifdef GRANT_MUX_STATS_EN
            for (int i = 0; i < W; i++) cnt_m[i] = 0;
`endif
        end
        occ     = pushed - popped;
        exp_rdy = (ones(g) == 1 && (!r || occ < 2)) ? g : '0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(occ > 0));
        chk("err_grant", 64'(err_grant), 64'(err_m));
`ifdef GRANT_MUX_STATS_EN
        for (int i = 0; i < W; i++)
            chk($sformatf("stat_cnt[%0d]", i), 64'(stat_cnt[i*16 +: 16]), 64'(cnt_m[i]));
`endif
        if (r) begin
            if (ones(g) > 1) err_m = 1'b1;
            if ((exp_rdy & v) != '0) begin
                idx = 0;
                for (int i = 0; i < W; i++) if (g[i]) idx = i;
                sb.push_back({SW'(idx), d[idx*DW +: DW]});
                pushed++;
`ifdef GRANT_MUX_STATS_EN
                if (!clr && cnt_m[idx] < 65535) cnt_m[idx]++;
`endif
            end
`ifdef GRANT_MUX_STATS_EN
            if (clr) for (int i = 0; i < W; i++) cnt_m[i] = 0;
`endif
        end
`ifndef GRANT_MUX_STATS_EN
        if (clr) idx = 0;
`endif
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h/%0h required=none", out_src, out_data);
                end else begin
                    b = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(b.data));
                    chk("out_src", 64'(out_src), 64'(b.src));
                    popped++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] g;
        // reset held with a live grant: ready follows grant, nothing captured
        repeat (3) step(1'b0, 4'b0001, 4'b1111, rnd_data(), 1'b0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0);

        // streaming, one beat per cycle
        for (int i = 0; i < W; i++) step(1'b1, W'(1 << i), 4'b1111, a_data(), 1'b1, 1'b0);
        repeat (2) step(1'b1, 4'b0000, 4'b0000, a_data(), 1'b1, 1'b0);

        // backpressure fills main + skid, then release
        repeat (4) step(1'b1, 4'b0010, 4'b0010, rnd_data(), 1'b0, 1'b0);
        repeat (4) step(1'b1, 4'b0010, 4'b0010, rnd_data(), 1'b1, 1'b0);
        repeat (3) step(1'b1, 4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0);

        // illegal grant, sticky error until reset
        repeat (2) step(1'b1, 4'b0110, 4'b1111, rnd_data(), 1'b1, 1'b0);
        repeat (2) step(1'b1, 4'b0001, 4'b0000, rnd_data(), 1'b1, 1'b0);
        step(1'b0, 4'b0001, 4'b0000, rnd_data(), 1'b1, 1'b0);
        step(1'b1, 4'b0000, 4'b1111, rnd_data(), 1'b1, 1'b0);

        // idle grant, then async reset during a stall
        repeat (2) step(1'b1, 4'b0000, 4'b1111, rnd_data(), 1'b1, 1'b0);
        repeat (2) step(1'b1, 4'b0001, 4'b0001, rnd_data(), 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'b0001, rnd_data(), 1'b0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0:       g = '0;
                default: g = W'(1 << $urandom_range(0, W-1));
            endcase
            if ($urandom_range(0, 99) == 0) g = 4'b1001;
            step(($urandom_range(0, 299) != 0), g, W'($urandom), rnd_data(),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        end
        step(1'b0, 4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0);

`ifdef GRANT_MUX_STATS_EN
        repeat (3) step(1'b1, 4'b0100, 4'b0100, rnd_data(), 1'b1, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0);
        step(1'b1, 4'b0100, 4'b0100, rnd_data(), 1'b1, 1'b1);
        step(1'b1, 4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0);
        repeat (65540) step(1'b1, 4'b0001, 4'b0001, rnd_data(), 1'b1, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0);
`endif

        repeat (4) step(1'b1, 4'b0000, 4'b0000, rnd_data(), 1'b1, 1'b0);
        chk("drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
